// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
// The producer and consumer side (master) drives operands and out_ready;
// the arithmetic core (slave) drives in_ready and the result with flags.
interface cla_pipe_addsub_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             co;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, ci, sub, out_ready,
      input  in_ready, out_valid, s, co, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, ci, sub, out_ready,
      output in_ready, out_valid, s, co, ovf, zero
   );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
// Level j of the pipe resolves bit slice j; operands for later slices travel
// forward unchanged (input skew) and finished sum slices ride along until the
// last level (output deskew), so the whole result leaves aligned.
// A single stall (result valid but not taken) freezes every level.
module cla_pipe_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input logic               clk,
   input logic               rst,
   cla_pipe_addsub_if.slave  bus
);
   localparam int SW = WIDTH / STAGES;  // bits resolved per level
   localparam int NG = SW / 4;          // lookahead groups per level

   // 4-bit lookahead group: returns {carry out, carry into bit 3, sum}
   function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
      logic [3:0] g;
      logic [3:0] p;
      logic       c1, c2, c3, c4;
      g  = x & y;
      p  = x ^ y;
      c1 = g[0] | (p[0] & c0);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c4, c3, p ^ {c3, c2, c1, c0}};
   endfunction

   // One level: groups ripple their carries; returns {carry into top bit, carry out, sum}
   function automatic logic [SW+1:0] cla_stage(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic cin);
      logic [SW-1:0] sm;
      logic          c;
      logic          cm;
      logic [5:0]    r;
      sm = {SW{1'b0}};
      c  = cin;
      cm = cin;
      for (int gi = 0; gi < NG; gi++) begin
         r = cla4(x[gi*4 +: 4], y[gi*4 +: 4], c);
         sm[gi*4 +: 4] = r[3:0];
         cm = r[4];
         c  = r[5];
      end
      return {cm, c, sm};
   endfunction

   logic             stall;
   logic             advance;
   logic [WIDTH-1:0] b_eff;
   logic             c_first;

   logic [WIDTH-1:0] a_r  [STAGES];
   logic [WIDTH-1:0] b_r  [STAGES];
   logic [WIDTH-1:0] s_r  [STAGES];
   logic [STAGES-1:0] c_r, cm_r, vld_r;

   logic [WIDTH-1:0] a_nx [STAGES];
   logic [WIDTH-1:0] b_nx [STAGES];
   logic [WIDTH-1:0] s_nx [STAGES];
   logic [STAGES-1:0] c_nx, cm_nx, vld_nx;

   assign stall   = vld_r[STAGES-1] & ~bus.out_ready;
   assign advance = ~stall;

   // Subtraction is A + ~B + 1; the caller's carry-in only matters for add
   always_comb begin
      b_eff   = bus.b;
      c_first = bus.ci;
      if (bus.sub) begin
         b_eff   = ~bus.b;
         c_first = 1'b1;
      end else begin
         b_eff   = bus.b;
         c_first = bus.ci;
      end
   end

   // Per level: take what arrives from the level before and resolve this level's slice
   always_comb begin
      int              prev;
      logic            c_in;
      logic [SW+1:0]   res;
      for (int j = 0; j < STAGES; j++) begin
         prev = (j > 0) ? j - 1 : 0;
         if (j == 0) begin
            a_nx[j]   = bus.a;
            b_nx[j]   = b_eff;
            s_nx[j]   = {WIDTH{1'b0}};
            c_in      = c_first;
            vld_nx[j] = bus.in_valid;
         end else begin
            a_nx[j]   = a_r[prev];
            b_nx[j]   = b_r[prev];
            s_nx[j]   = s_r[prev];
            c_in      = c_r[prev];
            vld_nx[j] = vld_r[prev];
         end
         res = cla_stage(a_nx[j][j*SW +: SW], b_nx[j][j*SW +: SW], c_in);
         s_nx[j][j*SW +: SW] = res[SW-1:0];
         c_nx[j]  = res[SW];
         cm_nx[j] = res[SW+1];
      end
   end

   // Pipe registers: cleared by reset, frozen as a whole while the result is stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < STAGES; j++) begin
            a_r[j] <= {WIDTH{1'b0}};
            b_r[j] <= {WIDTH{1'b0}};
            s_r[j] <= {WIDTH{1'b0}};
         end
         c_r   <= {STAGES{1'b0}};
         cm_r  <= {STAGES{1'b0}};
         vld_r <= {STAGES{1'b0}};
      end else if (advance) begin
         for (int j = 0; j < STAGES; j++) begin
            a_r[j] <= a_nx[j];
            b_r[j] <= b_nx[j];
            s_r[j] <= s_nx[j];
         end
         c_r   <= c_nx;
         cm_r  <= cm_nx;
         vld_r <= vld_nx;
      end
   end

   assign bus.in_ready  = ~stall;
   assign bus.out_valid = vld_r[STAGES-1];
   assign bus.s         = s_r[STAGES-1];
   assign bus.co        = c_r[STAGES-1];
   assign bus.ovf       = cm_r[STAGES-1] ^ c_r[STAGES-1];
   assign bus.zero      = ~|s_r[STAGES-1];
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub: 32-bit/2-level streaming core with a
// result scoreboard, plus 8-bit/1-level and 64-bit/4-level corner sweeps.
module tb_cla_pipe_addsub;
   logic clk;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   bit   mon_en = 1'b0;

   typedef struct {
      logic [66:0] exp;
      int          due;
   } exp_t;
   exp_t exp_q[$];

   cla_pipe_addsub_if #(.WIDTH(32)) bus32();
   cla_pipe_addsub_if #(.WIDTH(8))  bus8();
   cla_pipe_addsub_if #(.WIDTH(64)) bus64();

   cla_pipe_addsub #(.WIDTH(32), .STAGES(2)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
   cla_pipe_addsub #(.WIDTH(8),  .STAGES(1)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
   cla_pipe_addsub #(.WIDTH(64), .STAGES(4)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cycle counter used for latency checks
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [66:0] pack(input logic co, input logic ovf, input logic zero, input logic [63:0] s);
      return {co, ovf, zero, s};
   endfunction

   // reference: wide integer add, flags from operand/result signs
   function automatic logic [66:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                         input logic ci, input logic sub);
      logic [63:0] m, bb, r;
      logic [64:0] full;
      logic        c0, co, ovf;
      m    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      bb   = (sub ? ~b : b) & m;
      c0   = sub ? 1'b1 : ci;
      full = {1'b0, a & m} + {1'b0, bb} + {64'd0, c0};
      r    = full[63:0] & m;
      co   = full[w];
      ovf  = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
      return pack(co, ovf, (r == 64'd0), r);
   endfunction

   // 32-bit result monitor: compares against the scoreboard head; holds during stall
   always @(negedge clk) begin
      if (mon_en && bus32.out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out32", 67'(bus32.out_valid), 67'(1'b0));
         end else begin
            check("res32", pack(bus32.co, bus32.ovf, bus32.zero, {32'h0, bus32.s}), exp_q[0].exp);
            if (bus32.out_ready) begin
               if (exp_q[0].due >= 0) check("latency32", 67'(cyc), 67'(exp_q[0].due));
               exp_q.delete(0);
            end else begin
               check("stall_in_ready32", 67'(bus32.in_ready), 67'(1'b0));
            end
         end
      end
   end

   task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sub,
                         input logic [66:0] exp, input bit lat);
      bit   acc;
      int   tries;
      exp_t e;
      bus32.a = a; bus32.b = b; bus32.ci = ci; bus32.sub = sub; bus32.in_valid = 1'b1;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
         @(negedge clk);
         acc = bus32.in_ready;
         if (acc) begin
            e.exp = exp;
            e.due = lat ? cyc + 2 : -1;
            exp_q.push_back(e);
         end
         @(posedge clk); #1;
         tries++;
      end
      check("accept32", 67'(acc), 67'(1'b1));
      bus32.in_valid = 1'b0;
   endtask

   task automatic vec8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub,
                       input logic [66:0] exp);
      bus8.a = a; bus8.b = b; bus8.ci = ci; bus8.sub = sub; bus8.in_valid = 1'b1;
      @(negedge clk);
      check("w8_ready", 67'(bus8.in_ready), 67'(1'b1));
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      @(negedge clk);
      check("w8_valid", 67'(bus8.out_valid), 67'(1'b1));
      check("w8_res", pack(bus8.co, bus8.ovf, bus8.zero, {56'h0, bus8.s}), exp);
      @(posedge clk); #1;
   endtask

   task automatic vec64(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic sub,
                        input logic [66:0] exp);
      bus64.a = a; bus64.b = b; bus64.ci = ci; bus64.sub = sub; bus64.in_valid = 1'b1;
      @(posedge clk); #1;
      bus64.in_valid = 1'b0;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         check("w64_early", 67'(bus64.out_valid), 67'(1'b0));
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("w64_valid", 67'(bus64.out_valid), 67'(1'b1));
      check("w64_res", pack(bus64.co, bus64.ovf, bus64.zero, bus64.s), exp);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      logic        rc, rs;
      rst = 1'b0;
      bus32.in_valid = 1'b0; bus32.a = 32'h0; bus32.b = 32'h0; bus32.ci = 1'b0; bus32.sub = 1'b0; bus32.out_ready = 1'b1;
      bus8.in_valid  = 1'b0; bus8.a  = 8'h0;  bus8.b  = 8'h0;  bus8.ci  = 1'b0; bus8.sub  = 1'b0; bus8.out_ready  = 1'b1;
      bus64.in_valid = 1'b0; bus64.a = 64'h0; bus64.b = 64'h0; bus64.ci = 1'b0; bus64.sub = 1'b0; bus64.out_ready = 1'b1;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid32", 67'(bus32.out_valid), 67'(1'b0));
      check("rst_s32",     67'(bus32.s),         67'(32'h0));
      check("rst_co32",    67'(bus32.co),        67'(1'b0));
      check("rst_ovf32",   67'(bus32.ovf),       67'(1'b0));
      check("rst_zero32",  67'(bus32.zero),      67'(1'b1));
      check("rst_ready32", 67'(bus32.in_ready),  67'(1'b1));
      check("rst_valid8",  67'(bus8.out_valid),  67'(1'b0));
      check("rst_zero8",   67'(bus8.zero),       67'(1'b1));
      check("rst_valid64", 67'(bus64.out_valid), 67'(1'b0));
      check("rst_zero64",  67'(bus64.zero),      67'(1'b1));
      rst = 1'b0;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // directed 32-bit beats, back to back
      send32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, pack(1'b1, 1'b0, 1'b1, 64'h0), 1'b1);
      send32(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, pack(1'b0, 1'b0, 1'b0, 64'h0001_0000), 1'b1);
      send32(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, pack(1'b0, 1'b0, 1'b0, 64'hFFFF_FFFE), 1'b1);
      send32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, pack(1'b1, 1'b1, 1'b0, 64'h7FFF_FFFF), 1'b1);
      send32(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, pack(1'b1, 1'b0, 1'b0, 64'h0000_0007), 1'b1);
      send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, pack(1'b0, 1'b1, 1'b0, 64'h8000_0000), 1'b1);
      for (int i = 0; i < 20; i++) begin
         ra = $urandom; rb = $urandom;
         rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
         send32(ra, rb, rc, rs, model(32, {32'h0, ra}, {32'h0, rb}, rc, rs), 1'b1);
      end
      repeat (4) @(posedge clk); #1;
      check("drain_stream", 67'(exp_q.size()), 67'(0));

      // back-pressure: consumer stops for 3 cycles with the pipe full
      fork
         begin
            logic [31:0] pa, pb;
            logic        pc, ps;
            for (int i = 0; i < 10; i++) begin
               pa = $urandom; pb = $urandom;
               pc = 1'($urandom_range(0, 1)); ps = 1'($urandom_range(0, 1));
               send32(pa, pb, pc, ps, model(32, {32'h0, pa}, {32'h0, pb}, pc, ps), 1'b0);
            end
         end
         begin
            repeat (4) @(posedge clk);
            #1 bus32.out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 bus32.out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk); #1;
      check("drain_stall", 67'(exp_q.size()), 67'(0));

      // reset with two beats in flight
      send32(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, pack(1'b0, 1'b0, 1'b0, 64'h3), 1'b1);
      send32(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, pack(1'b0, 1'b0, 1'b0, 64'h7), 1'b1);
      mon_en = 1'b0;
      check("pre_rst_valid", 67'(bus32.out_valid), 67'(1'b1));
      #1 rst = 1'b1;
      #1;
      check("mid_rst_valid", 67'(bus32.out_valid), 67'(1'b0));
      check("mid_rst_zero",  67'(bus32.zero),      67'(1'b1));
      check("mid_rst_s",     67'(bus32.s),         67'(32'h0));
      check("mid_rst_co",    67'(bus32.co),        67'(1'b0));
      check("mid_rst_ready", 67'(bus32.in_ready),  67'(1'b1));
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_rst_idle", 67'(bus32.out_valid), 67'(1'b0));
      end
      @(posedge clk); #1;
      send32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, pack(1'b0, 1'b0, 1'b0, 64'h2345_6789), 1'b1);
      repeat (4) @(posedge clk); #1;
      check("drain_post_rst", 67'(exp_q.size()), 67'(0));

      // 8-bit, single level
      vec8(8'hFF, 8'h01, 1'b0, 1'b0, pack(1'b1, 1'b0, 1'b1, 64'h00));
      vec8(8'h7F, 8'h01, 1'b0, 1'b0, pack(1'b0, 1'b1, 1'b0, 64'h80));
      vec8(8'h80, 8'h01, 1'b0, 1'b1, pack(1'b1, 1'b1, 1'b0, 64'h7F));
      vec8(8'h00, 8'h00, 1'b0, 1'b1, pack(1'b1, 1'b0, 1'b1, 64'h00));
      vec8(8'hFF, 8'hFF, 1'b1, 1'b0, pack(1'b1, 1'b0, 1'b0, 64'hFF));
      vec8(8'h80, 8'h80, 1'b0, 1'b0, pack(1'b1, 1'b1, 1'b1, 64'h00));
      vec8(8'h00, 8'hFF, 1'b1, 1'b1, pack(1'b0, 1'b0, 1'b0, 64'h01));

      // 64-bit, four levels
      vec64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, pack(1'b1, 1'b0, 1'b1, 64'h0));
      vec64(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, pack(1'b0, 1'b1, 1'b0, 64'h8000_0000_0000_0000));
      vec64(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, pack(1'b1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF));
      vec64(64'h0, 64'h0, 1'b1, 1'b1, pack(1'b1, 1'b0, 1'b1, 64'h0));
      vec64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
            pack(1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF));
      vec64(64'h0, 64'h0, 1'b1, 1'b0, pack(1'b0, 1'b0, 1'b0, 64'h1));
      vec64(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, pack(1'b0, 1'b0, 1'b0, 64'h0000_0001_0000_0000));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
